// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   XLEN / ILEN      : address and instruction widths
//   DEFAULT_RESET_PC : default byte address fetched first after reset
//   fetch_state_t    : fetch sequencer state (RUN, FAULT)
//   fetch_entry_t    : one buffered fetch result {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry FIFO of fetch results between the memory return path and decode.
// Ports:
//   clk, n_rst    : clock, asynchronous active-low reset
//   i_push        : write i_push_data at the tail
//   i_push_data   : {pc, instr} entry to store
//   i_pop         : remove the head entry (ignored when empty)
//   i_flush       : discard all entries; overrides push and pop
//   o_head        : head entry, all-zero when empty
//   o_count       : number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by r_count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Program counter and fetch sequencer in front of a synchronous instruction
// memory with one cycle of read latency. Issues sequential word addresses,
// buffers returned words in a 2-entry queue toward decode, handles redirects
// and halts on misaligned or out-of-range fetch addresses.
// Parameters:
//   RESET_PC  : byte address fetched first after reset
//   NUM_INSTR : instruction memory depth in words
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   pc_out            : byte address presented to the memory (registered)
//   mem_instr         : memory read data for the address of the previous edge
//   redirect_valid/pc : single-cycle redirect request and its target
//   if_valid/ready    : handshake toward decode
//   if_instr/if_pc    : instruction word and its address at the queue head
//   fault/fault_pc    : fetch halted, and the offending address
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              NUM_INSTR = 1024
) (
  input  logic            clk,
  input  logic            n_rst,
  output logic [XLEN-1:0] pc_out,
  input  logic [ILEN-1:0] mem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam logic [XLEN-1:0] LIMIT = XLEN'(NUM_INSTR);

  function automatic logic legal(input logic [XLEN-1:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[XLEN-1:2]} < LIMIT);
  endfunction

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req_vld;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_fault_pc;

  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  logic         w_pc_legal;
  logic [2:0]   w_occ;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_ret;

  assign w_pc_legal = legal(r_pc);
  assign w_pop      = (w_count != 2'd0) && if_ready;
  assign w_push     = r_req_vld && !redirect_valid;

  // Occupancy the queue will have after this cycle; an issue now returns next
  // cycle, so it is allowed only while that leaves one free slot.
  assign w_occ   = {1'b0, w_count} + {2'b00, r_req_vld} - {2'b00, w_pop};
  assign w_issue = (r_state == RUN) && w_pc_legal && (w_occ < 3'd2) && !redirect_valid;

  // ---- stage 0: address issue / sequencer ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_req_vld  <= 1'b0;
      r_req_pc   <= '0;
      r_fault_pc <= '0;
    end else if (redirect_valid) begin
      r_req_vld <= 1'b0;
      r_pc      <= redirect_pc;
      if (legal(redirect_pc)) begin
        r_state <= RUN;
      end else begin
        r_state    <= FAULT;
        r_fault_pc <= redirect_pc;
      end
    end else begin
      r_req_vld <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + 32'd4;
      end
      // Sequential overrun: stop before issuing the illegal address.
      if ((r_state == RUN) && !w_pc_legal) begin
        r_state    <= FAULT;
        r_fault_pc <= r_pc;
      end
    end
  end

  // ---- stage 1: memory return into the decode queue ----
  assign w_ret.pc    = r_req_pc;
  assign w_ret.instr = mem_instr;

  fetch_fifo u_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (w_push),
    .i_push_data (w_ret),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign pc_out   = r_pc;
  assign if_valid = (w_count != 2'd0);
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;
  assign fault    = (r_state == FAULT);
  assign fault_pc = r_fault_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int NI = 1024;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] pc_out;
  logic [31:0] mem_instr = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_errors = 0;
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .NUM_INSTR(NI)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .pc_out         (pc_out),
    .mem_instr      (mem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h100 + {2'b00, a[31:2]};
  endfunction

  // Synchronous instruction memory: word i holds 0x100+i.
  always @(posedge clk) mem_instr <= memword(pc_out);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected delivery stream from a start address, stopping at the memory end.
  task automatic sb_load(input logic [31:0] start, input int n);
    fetch_entry_t e;
    logic [31:0] a;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      if (a[31:2] < 30'(NI)) begin
        e.pc    = a;
        e.instr = memword(a);
        sb.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    fetch_entry_t e;
    if (n_rst && !redirect_valid && if_valid && if_ready) begin
      check_eq("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("if_pc", if_pc, e.pc);
        check_eq("if_instr", if_instr, e.instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive a one-cycle redirect, then check the bubble and first target word.
  task automatic redirect_to(input logic [31:0] tgt, input logic expect_ok, input int nload);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    if_ready       = 1'b1;
    if (nload > 0) sb_load(tgt, nload);
    else sb.delete();
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_pc_out", pc_out, tgt);
    check_eq("rd_valid_r1", {31'b0, if_valid}, 32'd0);
    check_eq("rd_fault", {31'b0, fault}, {31'b0, ~expect_ok});
    step();
    @(negedge clk);
    check_eq("rd_valid_r2", {31'b0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_valid_r3", {31'b0, if_valid}, {31'b0, expect_ok});
    if (expect_ok) begin
      check_eq("rd_if_pc_r3", if_pc, tgt);
      check_eq("rd_if_instr_r3", if_instr, memword(tgt));
    end
  endtask

  initial begin
    logic [31:0] prev_pc;
    logic [31:0] stall_pc;

    n_rst          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #12;
    check_eq("rst_pc_out", pc_out, 32'h0);
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_fault", {31'b0, fault}, 32'd0);
    check_eq("rst_fault_pc", fault_pc, 32'h0);

    // Reset release and first-word latency.
    sb_load(32'h0, 64);
    @(posedge clk); #1;
    n_rst = 1'b1;
    step();
    @(negedge clk);
    check_eq("first_valid_c1", {31'b0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    check_eq("first_valid_c2", {31'b0, if_valid}, 32'd1);
    check_eq("first_if_pc", if_pc, 32'h0);
    check_eq("first_pc_out", pc_out, 32'h8);
    prev_pc = pc_out;

    // Steady state: one word per cycle, no gaps.
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      check_eq("stream_valid", {31'b0, if_valid}, 32'd1);
      check_eq("stream_pc_out", pc_out, prev_pc + 32'd4);
      prev_pc = pc_out;
    end

    // Backpressure for 5 cycles.
    step();
    if_ready = 1'b0;
    @(negedge clk);
    stall_pc = pc_out;
    run(4);
    @(negedge clk);
    check_eq("stall_pc_hold", pc_out, stall_pc);
    check_eq("stall_valid", {31'b0, if_valid}, 32'd1);
    step();
    if_ready = 1'b1;
    run(6);
    @(negedge clk);
    check_eq("resume_valid", {31'b0, if_valid}, 32'd1);

    // Redirect while the queue is full.
    step();
    if_ready = 1'b0;
    run(3);
    redirect_to(32'h40, 1'b1, 64);
    run(4);

    // Misaligned redirect enters FAULT, issue stops.
    redirect_to(32'h42, 1'b0, 0);
    check_eq("mis_fault_pc", fault_pc, 32'h42);
    run(3);
    @(negedge clk);
    check_eq("mis_hold_valid", {31'b0, if_valid}, 32'd0);
    check_eq("mis_hold_pc", pc_out, 32'h42);
    check_eq("mis_hold_fault", {31'b0, fault}, 32'd1);

    // Legal redirect leaves FAULT.
    redirect_to(32'h8, 1'b1, 64);
    run(4);

    // Sequential overrun at the end of memory.
    redirect_to(32'hFF0, 1'b1, 8);
    run(12);
    @(negedge clk);
    check_eq("ovr_fault", {31'b0, fault}, 32'd1);
    check_eq("ovr_fault_pc", fault_pc, 32'h1000);
    check_eq("ovr_valid", {31'b0, if_valid}, 32'd0);
    check_eq("ovr_pc_out", pc_out, 32'h1000);
    check_eq("ovr_drained", sb.size(), 32'd0);

    // Asynchronous reset mid-stream with the queue filled.
    redirect_to(32'h0, 1'b1, 64);
    run(5);
    if_ready = 1'b0;
    run(2);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("arst_valid", {31'b0, if_valid}, 32'd0);
    check_eq("arst_pc_out", pc_out, 32'h0);
    check_eq("arst_if_pc", if_pc, 32'h0);
    check_eq("arst_fault", {31'b0, fault}, 32'd0);
    sb_load(32'h0, 64);
    @(posedge clk); #1;
    n_rst    = 1'b1;
    if_ready = 1'b1;
    step();
    @(negedge clk);
    check_eq("arst_valid_c1", {31'b0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    check_eq("arst_valid_c2", {31'b0, if_valid}, 32'd1);
    check_eq("arst_if_pc_c2", if_pc, 32'h0);
    run(6);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and fetch-sequencing stage directly upstream of the synchronous instruction memory. Drives the PC into the memory, tracks the one-cycle read latency, and buffers returned instructions in a 2-entry queue toward decode with a valid/ready handshake. Also handles branch/jump redirects and flags misaligned or out-of-range fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- NUM_INSTR, 1024, instruction memory depth in words; legal word index 0..NUM_INSTR-1
- clk  in  1  clock, all state on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- pc_out  out  32  byte address to instruction memory, sampled by memory every edge
- mem_instr  in  32  memory read data; holds mem[pc_out/4] as sampled on the previous edge
- redirect_valid  in  1  single-cycle redirect request (branch/jump/trap)
- redirect_pc  in  32  redirect target byte address
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts; transfer (pop) = if_valid && if_ready
- if_instr  out  32  instruction word at queue head
- if_pc  out  32  byte address of if_instr
- fault  out  1  fetch halted on illegal address
- fault_pc  out  32  offending address, valid while fault=1

## Operation
- Registers: pc_q (next address to issue), req_valid_q/req_pc_q (request in flight), 2-entry queue of {pc, instr} with count_q 0..2, state_q, fault_pc_q.
- pc_out = pc_q always (registered, no combinational path from inputs).
- issue = (state_q==RUN) && legal(pc_q) && (count_q + req_valid_q - pop) < 2 && !redirect_valid.
- On issue: req_valid_q<=1, req_pc_q<=pc_q, pc_q<=pc_q+4 (32-bit wrap). Otherwise req_valid_q<=0, pc_q holds.
- Return: when req_valid_q=1 and no redirect, {req_pc_q, mem_instr} pushed at end of cycle. Credit rule guarantees push never overflows; push and pop in same cycle allowed at any count.
- legal(a) = a[1:0]==0 && a[31:2] < NUM_INSTR.
- States: RUN, FAULT.
 - RUN -> FAULT when pc_q illegal (sequential overrun): no issue; fault_pc_q<=pc_q.
 - Any state, redirect_valid=1: queue flushed (count_q<=0, pop ignored), req_valid_q<=0 (in-flight word discarded). Target legal -> pc_q<=redirect_pc, state RUN. Target illegal -> pc_q<=redirect_pc, state FAULT, fault_pc_q<=redirect_pc.
 - FAULT: no issue; queued entries still drain to decode; exit only via legal redirect or reset.
- fault = (state_q==FAULT).
- if_valid = count_q!=0; if_instr/if_pc from head entry; X-free (zero) when empty.

## Timing
- Reset values: pc_q=RESET_PC (pc_out=RESET_PC), req_valid_q=0, count_q=0, if_valid=0, if_instr=0, if_pc=0, state RUN, fault=0, fault_pc=0.
- Fetch latency: address issued cycle t -> mem_instr cycle t+1 -> if_valid cycle t+2.
- First instruction after reset release: if_valid in 2nd cycle after first rising edge with n_rst=1.
- Steady state, if_ready=1: one instruction per cycle, consecutive PCs.
- if_ready=0: at most 2 words queued; issue stops; no word lost or duplicated; resume at full rate on the cycle if_ready returns.
- Redirect in cycle r: pc_out=target in r+1, target instr at if_valid in r+3; if_valid=0 in r+1 and r+2.
- Redirect wins over simultaneous pop, push, and fault entry.
- n_rst asserted mid-operation: all state returns to reset values immediately (async), in-flight and queued words dropped.

## Structure
- Package fetch_pkg: fetch_state_t enum {RUN, FAULT}, XLEN=32, ILEN=32, default RESET_PC constant, fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo: 2-entry FIFO of fetch_entry_t with push/pop/flush and count output; fetch_ctrl holds PC, credit logic, FSM.

## Test plan
- Reset, RESET_PC=0, if_ready=1, memory words 0..7 = 0x100+i -> pc_out 0,4,8,...; if_valid from cycle 2, if_instr 0x100,0x101,... with if_pc 0,4,8, no gaps.
- Hold if_ready=0 for 5 cycles mid-stream -> count saturates at 2, pc_out stops advancing, after release next if_instr sequence continues without skip or repeat.
- redirect_valid with redirect_pc=0x40 while queue full -> if_valid=0 for two cycles, then if_pc=0x40, if_instr=mem[16]; no pre-redirect words delivered.
- redirect_pc=0x42 -> fault=1, fault_pc=0x42, no further issue; then redirect_pc=0x8 -> fault=0, if_pc=0x8 three cycles later.
- NUM_INSTR=4, sequential run from 0 -> words at 0..0xC delivered, then fault=1, fault_pc=0x10, if_valid drops after queue drains.
- Assert n_rst with 2 entries queued and request in flight -> if_valid=0 immediately, pc_out=RESET_PC, sequence restarts from RESET_PC.
